// File: rtl/serial_axi_master_pkg.sv
// Shared types and constants for the serial-port AXI4-Lite bridge.
// Holds the FSM encoding, AXI response codes and the register-address helper.
package serial_axi_master_pkg;

    localparam int PORT_BITS = 3;
    localparam int REG_BITS  = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        RADDR,
        RDATA,
        RSP
    } state_t;

    // 16550 registers sit on 32-bit word boundaries, eight per port.
    function automatic logic [31:0] reg_addr(input logic [31:0]          base,
                                             input logic [PORT_BITS-1:0] port,
                                             input logic [REG_BITS-1:0]  rsel);
        return base + {24'h0, port, rsel, 2'b00};
    endfunction

endpackage

// File: rtl/serial_axi_master_if.sv
// Command/response channels plus the AXI4-Lite master bus of the bridge.
// The master modport is the bridge's view; slave is the environment's view.
interface serial_axi_master_if;
    import serial_axi_master_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_we;
    logic [PORT_BITS-1:0] cmd_port;
    logic [REG_BITS-1:0]  cmd_reg;
    logic [7:0]           cmd_wdata;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [7:0]           rsp_rdata;
    logic [1:0]           rsp_resp;
    logic                 rsp_timeout;

    logic [31:0]          m_awaddr;
    logic                 m_awvalid;
    logic                 m_awready;
    logic [31:0]          m_wdata;
    logic [3:0]           m_wstrb;
    logic                 m_wvalid;
    logic                 m_wready;
    logic [1:0]           m_bresp;
    logic                 m_bvalid;
    logic                 m_bready;

    logic [31:0]          m_araddr;
    logic [3:0]           m_aruser;
    logic                 m_arvalid;
    logic                 m_arready;
    logic [31:0]          m_rdata;
    logic [1:0]           m_rresp;
    logic                 m_rvalid;
    logic                 m_rready;

    modport master (
        input  cmd_valid, cmd_we, cmd_port, cmd_reg, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        input  rsp_ready,
        output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
        input  m_awready, m_wready, m_bresp, m_bvalid,
        output m_araddr, m_aruser, m_arvalid, m_rready,
        input  m_arready, m_rdata, m_rresp, m_rvalid
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_port, cmd_reg, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        output rsp_ready,
        input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
        output m_awready, m_wready, m_bresp, m_bvalid,
        input  m_araddr, m_aruser, m_arvalid, m_rready,
        output m_arready, m_rdata, m_rresp, m_rvalid
    );

endinterface

// File: rtl/serial_axi_master.sv
// Turns single-byte 16550 register commands into AXI4-Lite transactions,
// one at a time, with an optional response timeout.
module serial_axi_master
    import serial_axi_master_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 1023
) (
    input  logic                aclk,
    input  logic                areset,
    serial_axi_master_if.master bus
);

    // One spare count of headroom so the saturation value always fits.
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    state_t               state, state_nx;
    logic [CW-1:0]        cnt;
    logic                 we_q;
    logic [PORT_BITS-1:0] port_q;
    logic [REG_BITS-1:0]  reg_q;
    logic [7:0]           wdata_q;
    logic                 aw_done, w_done;
    logic [7:0]           rdata_q;
    logic [1:0]           resp_q;
    logic                 to_q;

    logic cmd_acc, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
    logic busy, to_hit, rsp_ld, rsp_to;
    logic unused_rdata_hi;

    assign cmd_acc = bus.cmd_valid && bus.cmd_ready;
    assign aw_hs   = bus.m_awvalid && bus.m_awready;
    assign w_hs    = bus.m_wvalid  && bus.m_wready;
    assign b_hs    = bus.m_bvalid  && bus.m_bready;
    assign ar_hs   = bus.m_arvalid && bus.m_arready;
    assign r_hs    = bus.m_rvalid  && bus.m_rready;
    assign rsp_hs  = bus.rsp_valid && bus.rsp_ready;

    assign busy   = (state == WRITE) || (state == WRESP) ||
                    (state == RADDR) || (state == RDATA);
    assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_MAX);

    assign bus.m_awaddr    = reg_addr(BASE_ADDR, port_q, reg_q);
    assign bus.m_araddr    = reg_addr(BASE_ADDR, port_q, reg_q);
    assign bus.m_wdata     = {24'h0, wdata_q};
    assign bus.m_wstrb     = 4'b0001;
    assign bus.m_aruser    = 4'b0001;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_resp    = resp_q;
    assign bus.rsp_timeout = to_q;
    assign unused_rdata_hi = ^bus.m_rdata[31:8];

    // Outputs decode from registered state only, never from AXI readies.
    always_comb begin
        state_nx      = state;
        rsp_ld        = 1'b0;
        rsp_to        = 1'b0;
        bus.cmd_ready = (state == IDLE);
        bus.m_awvalid = (state == WRITE) && !aw_done;
        bus.m_wvalid  = (state == WRITE) && !w_done;
        bus.m_bready  = (state == WRESP);
        bus.m_arvalid = (state == RADDR);
        bus.m_rready  = (state == RDATA);
        bus.rsp_valid = (state == RSP);
        case (state)
            IDLE:
                if (cmd_acc) state_nx = bus.cmd_we ? WRITE : RADDR;
            WRITE:
                if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = WRESP;
                else if (to_hit) begin state_nx = RSP; rsp_to = 1'b1; end
            WRESP:
                if (b_hs) begin state_nx = RSP; rsp_ld = 1'b1; end
                else if (to_hit) begin state_nx = RSP; rsp_to = 1'b1; end
            RADDR:
                if (ar_hs) state_nx = RDATA;
                else if (to_hit) begin state_nx = RSP; rsp_to = 1'b1; end
            RDATA:
                if (r_hs) begin state_nx = RSP; rsp_ld = 1'b1; end
                else if (to_hit) begin state_nx = RSP; rsp_to = 1'b1; end
            RSP:
                if (rsp_hs) state_nx = IDLE;
            default:
                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            port_q  <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata_q <= '0;
            resp_q  <= RESP_OKAY;
            to_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (cmd_acc) begin
                we_q    <= bus.cmd_we;
                port_q  <= bus.cmd_port;
                reg_q   <= bus.cmd_reg;
                wdata_q <= bus.cmd_wdata;
                cnt     <= '0;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (busy && cnt != CNT_MAX) begin
                // Saturate so a late phase still sees the expiry condition.
                cnt <= cnt + CW'(1);
            end
            if (state == WRITE) begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            if (rsp_ld) begin
                resp_q  <= we_q ? bus.m_bresp : bus.m_rresp;
                rdata_q <= we_q ? 8'h00 : bus.m_rdata[7:0];
                to_q    <= 1'b0;
            end else if (rsp_to) begin
                resp_q  <= RESP_DECERR;
                rdata_q <= 8'h00;
                to_q    <= 1'b1;
            end
        end
    end

endmodule

// File: doc/serial_axi_master.md
SERIAL_AXI_MASTER -- requirements
Module: serial_axi_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000; AXI byte address of serial port 0, register 0.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1023; response timeout in aclk cycles; 0 disables the timeout.
REQ-003 SHALL have port aclk  in  1  clock; one clock domain, all logic on the rising edge.
REQ-004 SHALL have port areset  in  1  reset; synchronous, active-high.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_we in 1 (1=write), cmd_port in 3 (port index), cmd_reg in 3 (16550 register offset), cmd_wdata in 8; the command channel.
REQ-006 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out 8, rsp_resp out 2 (AXI response code), rsp_timeout out 1; the response channel.
REQ-007 SHALL have AXI4-Lite master ports m_awaddr out 32, m_awvalid out 1, m_awready in 1, m_wdata out 32, m_wstrb out 4, m_wvalid out 1, m_wready in 1, m_bresp in 2, m_bvalid in 1, m_bready out 1.
REQ-008 SHALL have AXI4-Lite master ports m_araddr out 32, m_aruser out 4, m_arvalid out 1, m_arready in 1, m_rdata in 32, m_rresp in 2, m_rvalid in 1, m_rready out 1.

Function
REQ-009 SHALL accept a command when cmd_valid&&cmd_ready; cmd_ready SHALL be high only in IDLE; command fields SHALL be latched on acceptance.
REQ-010 SHALL form the address as BASE_ADDR + {cmd_port,cmd_reg,2'b00}, 32-bit wrap-around addition; m_awaddr and m_araddr SHALL both carry this address.
REQ-011 SHALL drive m_wdata={24'h0,cmd_wdata}, m_wstrb=4'b0001, m_aruser=4'b0001.
REQ-012 SHALL use states IDLE, WRITE, WRESP, RADDR, RDATA, RSP.
REQ-013 On a write, IDLE->WRITE SHALL assert m_awvalid and m_wvalid in the next cycle; each SHALL deassert independently after its own handshake; the channels SHALL be accepted in either order or in the same cycle.
REQ-014 WRITE->WRESP SHALL occur when both AW and W have completed; m_bready SHALL be high only in WRESP.
REQ-015 On a read, IDLE->RADDR SHALL assert m_arvalid; RADDR->RDATA SHALL occur on the AR handshake; m_rready SHALL be high only in RDATA.
REQ-016 On the B or R handshake the block SHALL go to RSP, latch rsp_resp from bresp/rresp, latch rsp_rdata=m_rdata[7:0] (reads) or 8'h00 (writes), and set rsp_timeout=0.
REQ-017 rsp_valid SHALL be high only in RSP; RSP->IDLE SHALL occur on rsp_valid&&rsp_ready; the response values SHALL be held stable until that handshake.
REQ-018 The timeout counter SHALL clear on command acceptance and increment each cycle in WRITE/WRESP/RADDR/RDATA; when it reaches TIMEOUT_CYCLES, the next cycle SHALL drop all AXI valid/ready outputs and enter RSP with rsp_timeout=1, rsp_resp=2'b11, rsp_rdata=8'h00.
REQ-019 A handshake completing in the same cycle the counter reaches TIMEOUT_CYCLES SHALL take priority; the response SHALL be normal.
REQ-020 AXI valid outputs SHALL NOT depend combinationally on any AXI ready input.
REQ-021 Minimum latency: write accepted at cycle 0 with awready=wready=bvalid=1 SHALL give rsp_valid at cycle 3; read with arready=rvalid=1 SHALL give rsp_valid at cycle 3.

Reset
REQ-022 With areset high at a clock edge, the state SHALL go to IDLE and the counter and latched fields SHALL clear.
REQ-023 Reset values SHALL be: cmd_ready=1 (the cycle after reset deasserts), all valid/ready outputs=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0, m_awaddr/m_araddr=BASE_ADDR, m_wdata=0.
REQ-024 A reset asserted mid-transaction SHALL abandon the transaction with no response; a stale slave response arriving later is a system error.

Structure
REQ-025 A shared package SHALL hold the state encoding, AXI response constants (OKAY=0, SLVERR=2, DECERR=3), and the width constants PORT_BITS=3 and REG_BITS=3.
REQ-026 The block SHALL be a single flat module with no sub-modules.

Verification
REQ-027 Write port 5, reg 3, data 8'hA5, with BASE_ADDR=32'h1000 -> m_awaddr=32'h10AC, m_wdata=32'h000000A5, m_wstrb=1, rsp_resp=0, rsp_timeout=0.
REQ-028 Read port 2, reg 5, slave rdata=32'h12345660, rresp=0 -> m_araddr=BASE+32'h54, m_aruser=1, rsp_rdata=8'h60.
REQ-029 Write with awready delayed 4 cycles after wready, then bresp=2 -> exactly one AW and one W handshake, rsp_resp=2'b10.
REQ-030 TIMEOUT_CYCLES=8, arready tied 0 -> m_arvalid drops after 9 cycles, rsp_timeout=1, rsp_resp=3; the next command then completes normally.
REQ-031 rsp_ready held low for 10 cycles -> rsp fields stable and cmd_ready=0 throughout; areset pulse during RDATA -> IDLE with all outputs at reset values.
